// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel word to serial bit stream with one-word holding register
// Optional SER_LSB_FIRST_EN: send bit 0 first instead of bit WIDTH-1.
module bit_stream_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       Din_Valid,
    output logic                       Din_Ready,
    input  logic                       Sout_En,
    output logic                       Sout,
    output logic                       Sout_Valid,
    output logic [$clog2(WIDTH)-1:0]   Bit_Cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_next;
    logic             xfer;
    logic             last_adv;

    assign Din_Ready = ~hold_full;
    assign xfer      = Din_Valid & ~hold_full;
    assign last_adv  = (state == SHIFT) & Sout_En & (bit_cnt == LAST);

    // Zero fill means the shifter is all-zero once a word has fully drained,
    // so the output bit is 0 in IDLE without extra gating.
`ifdef SER_LSB_FIRST_EN
    assign shift_next = {1'b0, shifter[WIDTH-1:1]};
    assign Sout       = shifter[0];
`else
    assign shift_next = {shifter[WIDTH-2:0], 1'b0};
    assign Sout       = shifter[WIDTH-1];
`endif

    assign Sout_Valid = (state == SHIFT);
    assign Bit_Cnt    = bit_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else if (state == IDLE) begin
            if (xfer) begin
                shifter <= Din;
                bit_cnt <= '0;
                state   <= SHIFT;
            end
        end else begin
            if (Sout_En) begin
                if (bit_cnt == LAST) begin
                    bit_cnt <= '0;
                    if (hold_full) begin
                        shifter   <= hold;
                        hold_full <= 1'b0;
                    end else if (xfer) begin
                        shifter <= Din;
                    end else begin
                        shifter <= shift_next;
                        state   <= IDLE;
                    end
                end else begin
                    shifter <= shift_next;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            // A word arriving on the last advancing bit bypasses the holding register.
            if (xfer && !last_adv) begin
                hold      <= Din;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - scoreboard bench for bit_stream_serializer, WIDTH=4
module tb_bit_stream_serializer;
    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [W-1:0] Din;
    logic         Din_Valid;
    logic         Din_Ready;
    logic         Sout_En;
    logic         Sout;
    logic         Sout_Valid;
    logic [1:0]   Bit_Cnt;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_q[$];

    bit_stream_serializer #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Din_Valid(Din_Valid), .Din_Ready(Din_Ready),
        .Sout_En(Sout_En), .Sout(Sout), .Sout_Valid(Sout_Valid), .Bit_Cnt(Bit_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected entries are {bit_cnt, bit} in transmission order.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
`ifdef SER_LSB_FIRST_EN
            exp_q.push_back({2'(i), w[i]});
`else
            exp_q.push_back({2'(i), w[W-1-i]});
`endif
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        logic rdy;
        bit   done;
        done      = 1'b0;
        Din       = w;
        Din_Valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = Din_Ready;
            step();
            if (rdy) done = 1'b1;
        end
        Din_Valid = 1'b0;
        if (done) push_word(w);
        else begin
            errors++;
            checks++;
            $display("FAIL send_timeout word=%0h", w);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 32'(Sout_Valid), 32'd0);
        check({name, "_sout"}, 32'(Sout), 32'd0);
        check({name, "_cnt"}, 32'(Bit_Cnt), 32'd0);
    endtask

    // Monitor: one expected entry per bit that advances (valid and enabled).
    always @(negedge Clk) begin
        if (!Rst && Sout_Valid && Sout_En) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit sout=%0b cnt=%0d required=none", Sout, Bit_Cnt);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("stream_bit", 32'(Sout), 32'(e[0]));
                check("stream_cnt", 32'(Bit_Cnt), 32'(e[2:1]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; Din = '0; Din_Valid = 1'b0; Sout_En = 1'b1;
        step(); step();
        Rst = 1'b0;
        check_idle("reset");
        check("reset_ready", 32'(Din_Ready), 32'd1);

        // Single word 1010
        send(4'b1010);
        repeat (4) step();
        check_idle("single_end");

        // Back-to-back 1010 then 1001
        send(4'b1010);
        send(4'b1001);
        check("b2b_ready_e1", 32'(Din_Ready), 32'd0);
        check("b2b_valid_e1", 32'(Sout_Valid), 32'd1);
        for (int i = 2; i < 8; i++) begin
            step();
            check("b2b_valid", 32'(Sout_Valid), 32'd1);
            check("b2b_ready", 32'(Din_Ready), (i >= 4) ? 32'd1 : 32'd0);
        end
        step();
        check_idle("b2b_end");

        // Stall at Bit_Cnt=1 for three cycles on 1100
        send(4'b1100);
        step();
        Sout_En = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_sout", 32'(Sout), 32'd1);
            check("stall_cnt", 32'(Bit_Cnt), 32'd1);
            if (i < 3) step();
        end
        Sout_En = 1'b1;
        repeat (3) step();
        check_idle("stall_end");

        // Reset mid-word with a word held
        send(4'b0110);
        send(4'b1111);
        check("rst_held_ready", 32'(Din_Ready), 32'd0);
        step();
        check("rst_pre_cnt", 32'(Bit_Cnt), 32'd2);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        exp_q.delete();
        check_idle("rst_after");
        check("rst_after_ready", 32'(Din_Ready), 32'd1);
        repeat (6) step();
        check_idle("rst_quiet");

        // Direct load on the last bit with empty holding register
        send(4'b1010);
        repeat (3) step();
        send(4'b0011);
        check("direct_valid", 32'(Sout_Valid), 32'd1);
        check("direct_cnt", 32'(Bit_Cnt), 32'd0);
        check("direct_sout", 32'(Sout), 32'd0);
        check("direct_ready", 32'(Din_Ready), 32'd1);
        repeat (4) step();
        check_idle("direct_end");

        // 1101: order depends on SER_LSB_FIRST_EN
        Sout_En = 1'b0;
        step();
        send(4'b1101);
        Sout_En = 1'b1;
        repeat (4) step();
        check_idle("order_end");

        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
